// File: rtl/galaksija_vram_pkg.sv
// Shared types and helpers for the Galaksija video RAM arbiter.
package galaksija_vram_pkg;

  typedef enum logic [2:0] {IDLE, PEND, GRANT, DATA, HOLD} arb_state_t;

  localparam logic [10:0] SCROLL_ADDR_DEF = 11'h3B0;
  localparam int          DEFER_W         = 4;

  // Codes 0..4 map to 12,9,6,3,0 font lines; anything larger pins to 0.
  function automatic logic [3:0] scroll_decode(input logic [7:0] d);
    logic [3:0] x;
    x = d[3:0];
    return (d <= 8'd4) ? (4'd12 - (x + x + x)) : 4'd0;
  endfunction

endpackage

// File: rtl/galaksija_vram_arbiter.sv
// Shares the single-port video RAM between fixed-latency video fetches and wait-stalled CPU
// accesses; also latches the write-only scroll register.
module galaksija_vram_arbiter
  import galaksija_vram_pkg::*;
#(
  parameter int             AW          = 11,
  parameter int             DW          = 8,
  parameter logic [AW-1:0]  SCROLL_ADDR = AW'(SCROLL_ADDR_DEF),
  parameter int             MAX_DEFER   = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_code,
  output logic          vid_valid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic [3:0]    scroll_offset,
  output logic          starve_err
);

  localparam logic [DEFER_W-1:0] MAX_DEFER_L = DEFER_W'(MAX_DEFER);

  arb_state_t         state_q, state_d;
  logic               wait_n_q, wait_n_d;
  logic [DEFER_W-1:0] defer_q, defer_d, defer_inc;
  logic               starve_q, starve_d;
  logic               cpu_grant;
  logic               cpu_req;
  logic               is_wr_q;
  logic [1:0]         vid_pipe_q;
  logic [AW-1:0]      ram_addr_q;
  logic [DW-1:0]      ram_din_q;
  logic               ram_we_q;
  logic [DW-1:0]      cpu_dout_q;
  logic [3:0]         scroll_q;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign defer_inc = (defer_q == '1) ? defer_q : defer_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    wait_n_d  = 1'b1;
    defer_d   = defer_q;
    starve_d  = starve_q;
    cpu_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          wait_n_d = 1'b0;
          if (vid_req) begin
            state_d = PEND;
          end else begin
            state_d   = GRANT;
            cpu_grant = 1'b1;
          end
        end
      end
      PEND: begin
        if (!cpu_req) begin
          state_d = IDLE;
          defer_d = '0;
        end else begin
          wait_n_d = 1'b0;
          if (defer_inc > MAX_DEFER_L) starve_d = 1'b1;
          if (vid_req) begin
            defer_d = defer_inc;
          end else begin
            state_d   = GRANT;
            cpu_grant = 1'b1;
            defer_d   = '0;
          end
        end
      end
      GRANT:   state_d = DATA;
      DATA:    state_d = HOLD;
      HOLD:    if (!cpu_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wait_n_q   <= 1'b1;
      defer_q    <= '0;
      starve_q   <= 1'b0;
      is_wr_q    <= 1'b0;
      vid_pipe_q <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      cpu_dout_q <= '0;
      scroll_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_n_q   <= wait_n_d;
      defer_q    <= defer_d;
      starve_q   <= starve_d;
      vid_pipe_q <= {vid_pipe_q[0], vid_req};
      if (vid_req) begin
        ram_addr_q <= vid_addr;
        ram_we_q   <= 1'b0;
      end else if (cpu_grant) begin
        ram_addr_q <= cpu_addr;
        ram_din_q  <= cpu_din;
        ram_we_q   <= cpu_wr;
        is_wr_q    <= cpu_wr;
      end else begin
        ram_we_q   <= 1'b0;
      end
      if (state_q == DATA && !is_wr_q) cpu_dout_q <= ram_dout;
      if (state_q == GRANT && is_wr_q && ram_addr_q == SCROLL_ADDR)
        scroll_q <= scroll_decode(ram_din_q[7:0]);
    end
  end

  // Read data comes straight from the RAM's output register in DATA, the same cycle wait_n rises.
  assign cpu_dout      = (state_q == DATA && !is_wr_q) ? ram_dout : cpu_dout_q;
  // Reset landing on a write cycle must not let that write reach the RAM.
  assign ram_we        = ram_we_q & resetn;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
  assign wait_n        = wait_n_q;
  assign vid_code      = ram_dout;
  assign vid_valid     = vid_pipe_q[1];
  assign scroll_offset = scroll_q;
  assign starve_err    = starve_q;

  a_vid_spacing: assert property (@(posedge clk) disable iff (!resetn) !(vid_req && vid_pipe_q[0]));

endmodule

// File: tb/tb_galaksija_vram_arbiter.sv
// Bench for galaksija_vram_arbiter: transaction-level CPU/video model against a behavioural RAM.
module tb_galaksija_vram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_rd, cpu_wr, vid_req;
  logic [10:0] cpu_addr, vid_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout, vid_code, ram_din, ram_dout;
  logic        wait_n, vid_valid, ram_we, starve_err;
  logic [10:0] ram_addr;
  logic [3:0]  scroll_offset;
  logic [7:0]  z_cpu_dout, z_vid_code, z_ram_din;
  logic        z_wait_n, z_vid_valid, z_ram_we, z_starve;
  logic [10:0] z_ram_addr;
  logic [3:0]  z_scroll;

  logic [7:0]  mem     [0:2047];
  logic [7:0]  ref_mem [0:2047];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          stop;

  typedef struct { int cyc; logic [7:0] code; } vexp_t;
  vexp_t vq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_din;
  end

  galaksija_vram_arbiter dut (
    .clk(clk), .resetn(resetn), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .wait_n(wait_n), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_code(vid_code), .vid_valid(vid_valid), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .scroll_offset(scroll_offset), .starve_err(starve_err));

  galaksija_vram_arbiter #(.MAX_DEFER(0)) dut0 (
    .clk(clk), .resetn(resetn), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(z_cpu_dout), .wait_n(z_wait_n), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_code(z_vid_code), .vid_valid(z_vid_valid), .ram_addr(z_ram_addr),
    .ram_din(z_ram_din), .ram_we(z_ram_we), .ram_dout(ram_dout),
    .scroll_offset(z_scroll), .starve_err(z_starve));

  function automatic int exp_scroll(int d);
    return (d <= 4) ? 12 - 3 * d : 0;
  endfunction

  // One CPU access as the CPU sees it: strobe up, wait for wait_n high, optional hold, strobe down.
  task automatic cpu_xfer(input bit wr, input logic [10:0] a, input logic [7:0] d, input int hold,
                          output logic [7:0] rd_data, output int lo);
    bit deferred, done;
    rd_data = 8'h00; lo = 0; done = 1'b0;
    @(posedge clk); #1;
    cpu_rd = !wr; cpu_wr = wr; cpu_addr = a; cpu_din = d;
    @(negedge clk);
    deferred = vid_req;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (wait_n === 1'b1) begin done = 1'b1; rd_data = cpu_dout; end
      else lo++;
    end
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL cpu_timeout addr=%h wait_n stuck low after %0d cycles", a, lo);
    end else begin
      n_tests++;
      if (lo != (deferred ? 2 : 1)) begin
        n_fail++; $display("FAIL wait_low_cycles addr=%h got %0d want %0d", a, lo, deferred ? 2 : 1);
      end
      if (!wr) begin
        if (rd_data !== ref_mem[a]) begin
          n_fail++; $display("FAIL cpu_read addr=%h got %h want %h", a, rd_data, ref_mem[a]);
        end
      end else begin
        ref_mem[a] = d;
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_tests++;
      if (wait_n !== 1'b1 || (!wr && cpu_dout !== rd_data)) begin
        n_fail++; $display("FAIL hold addr=%h wait_n=%b dout=%h want 1/%h", a, wait_n, cpu_dout, rd_data);
      end
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cpu_rd = 0; cpu_wr = 0; vid_req = 0; cpu_addr = '0; vid_addr = '0; cpu_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests += 9;
    if (cpu_dout !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_dout got %h want 00", cpu_dout); end
    if (wait_n !== 1'b1) begin n_fail++; $display("FAIL rst_wait_n got %b want 1", wait_n); end
    if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_vid_valid got %b want 0", vid_valid); end
    if (ram_addr !== 11'h000) begin n_fail++; $display("FAIL rst_ram_addr got %h want 000", ram_addr); end
    if (ram_din !== 8'h00) begin n_fail++; $display("FAIL rst_ram_din got %h want 00", ram_din); end
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we got %b want 0", ram_we); end
    if (scroll_offset !== 4'd0) begin n_fail++; $display("FAIL rst_scroll got %0d want 0", scroll_offset); end
    if (starve_err !== 1'b0) begin n_fail++; $display("FAIL rst_starve got %b want 0", starve_err); end
    if (z_starve !== 1'b0) begin n_fail++; $display("FAIL rst_starve0 got %b want 0", z_starve); end
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    @(posedge clk); #1;
    cpu_wr = 1'b1; cpu_addr = 11'h055; cpu_din = ~ref_mem[11'h055];
    @(posedge clk); #1;
    n_tests++;
    if (ram_we !== 1'b1) begin n_fail++; $display("FAIL midwr_we_before got %b want 1", ram_we); end
    resetn = 1'b0;
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    n_tests += 3;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL midwr_we_after got %b want 0", ram_we); end
    if (wait_n !== 1'b1) begin n_fail++; $display("FAIL midwr_wait_n got %b want 1", wait_n); end
    if (mem[11'h055] !== ref_mem[11'h055]) begin
      n_fail++; $display("FAIL midwr_ram got %h want %h", mem[11'h055], ref_mem[11'h055]);
    end
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  task automatic test_read();
    logic [7:0] rd; int lo;
    cpu_xfer(1'b0, 11'h010, 8'h00, 2, rd, lo);
    n_tests++;
    if (rd !== 8'h41) begin n_fail++; $display("FAIL read_010 got %h want 41", rd); end
  endtask

  task automatic test_vid_collision();
    logic [7:0] exp;
    @(posedge clk); #1;
    cpu_wr = 1'b1; cpu_addr = 11'h020; cpu_din = 8'h5A; vid_req = 1'b1; vid_addr = 11'h100;
    exp = ref_mem[11'h100];
    @(posedge clk); #1;
    vid_req = 1'b0;
    n_tests += 3;
    if (ram_addr !== 11'h100) begin n_fail++; $display("FAIL coll_vid_addr got %h want 100", ram_addr); end
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL coll_vid_we got %b want 0", ram_we); end
    if (wait_n !== 1'b0) begin n_fail++; $display("FAIL coll_wait_t1 got %b want 0", wait_n); end
    @(posedge clk); #1;
    cpu_din = 8'h00;
    n_tests += 6;
    if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL coll_vid_valid got %b want 1", vid_valid); end
    if (vid_code !== exp) begin n_fail++; $display("FAIL coll_vid_code got %h want %h", vid_code, exp); end
    if (ram_addr !== 11'h020) begin n_fail++; $display("FAIL coll_cpu_addr got %h want 020", ram_addr); end
    if (ram_we !== 1'b1) begin n_fail++; $display("FAIL coll_cpu_we got %b want 1", ram_we); end
    if (ram_din !== 8'h5A) begin n_fail++; $display("FAIL coll_cpu_din got %h want 5a", ram_din); end
    if (wait_n !== 1'b0) begin n_fail++; $display("FAIL coll_wait_t2 got %b want 0", wait_n); end
    @(posedge clk); #1;
    n_tests += 3;
    if (wait_n !== 1'b1) begin n_fail++; $display("FAIL coll_wait_t3 got %b want 1", wait_n); end
    if (mem[11'h020] !== 8'h5A) begin n_fail++; $display("FAIL coll_ram got %h want 5a", mem[11'h020]); end
    if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL coll_vid_valid_t3 got %b want 0", vid_valid); end
    ref_mem[11'h020] = 8'h5A;
    cpu_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cancel();
    @(posedge clk); #1;
    cpu_wr = 1'b1; cpu_addr = 11'h030; cpu_din = ~ref_mem[11'h030]; vid_req = 1'b1; vid_addr = 11'h101;
    @(posedge clk); #1;
    cpu_wr = 1'b0; vid_req = 1'b0;
    n_tests++;
    if (wait_n !== 1'b0) begin n_fail++; $display("FAIL cancel_wait_pend got %b want 0", wait_n); end
    @(posedge clk); #1;
    n_tests += 2;
    if (wait_n !== 1'b1) begin n_fail++; $display("FAIL cancel_wait_after got %b want 1", wait_n); end
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL cancel_we got %b want 0", ram_we); end
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (mem[11'h030] !== ref_mem[11'h030]) begin
      n_fail++; $display("FAIL cancel_ram got %h want %h", mem[11'h030], ref_mem[11'h030]);
    end
  endtask

  task automatic test_scroll();
    int dl[7] = '{0, 4, 2, 5, 1, 255, 3};
    logic [7:0] rd; int lo;
    for (int i = 0; i < 7; i++) begin
      cpu_xfer(1'b1, 11'h3B0, 8'(dl[i]), 0, rd, lo);
      n_tests += 2;
      if (scroll_offset !== 4'(exp_scroll(dl[i]))) begin
        n_fail++; $display("FAIL scroll d=%0d got %0d want %0d", dl[i], scroll_offset, exp_scroll(dl[i]));
      end
      if (mem[11'h3B0] !== 8'(dl[i])) begin
        n_fail++; $display("FAIL scroll_ram d=%0d got %h", dl[i], mem[11'h3B0]);
      end
    end
    cpu_xfer(1'b1, 11'h3B1, 8'h00, 0, rd, lo);
    n_tests++;
    if (scroll_offset !== 4'd3) begin n_fail++; $display("FAIL scroll_other_addr got %0d want 3", scroll_offset); end
    cpu_xfer(1'b0, 11'h3B0, 8'h00, 0, rd, lo);
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; int lo;
    for (int i = 0; i < 4; i++) begin
      cpu_xfer(1'b1, 11'h066 + 11'(i), 8'($urandom), 0, rd, lo);
      cpu_xfer(1'b0, 11'h066 + 11'(i), 8'h00, 0, rd, lo);
    end
  endtask

  task automatic test_random();
    int bad;
    stop = 1'b0;
    vq.delete();
    vid_req = 1'b0;
    fork
      begin
        for (int k = 0; k < 1200; k++) begin
          repeat (6) @(posedge clk);
          @(posedge clk); #1;
          vid_req = 1'b1;
          vid_addr = 11'h400 + 11'($urandom_range(0, 1023));
          vq.push_back('{cyc: cyc + 2, code: ref_mem[vid_addr]});
          @(posedge clk); #1;
          vid_req = 1'b0;
        end
        repeat (4) @(posedge clk);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(negedge clk);
          if (vid_valid === 1'b1) begin
            n_tests++;
            if (vq.size() == 0) begin
              n_fail++; $display("FAIL vid_spurious cyc=%0d code=%h", cyc, vid_code);
            end else begin
              if (vq[0].cyc != cyc || vid_code !== vq[0].code) begin
                n_fail++; $display("FAIL vid_fetch cyc=%0d code=%h want cyc=%0d code=%h",
                                   cyc, vid_code, vq[0].cyc, vq[0].code);
              end
              void'(vq.pop_front());
            end
          end else if (vq.size() != 0 && vq[0].cyc <= cyc) begin
            n_tests++; n_fail++;
            $display("FAIL vid_missing cyc=%0d valid=%b want valid at %0d", cyc, vid_valid, vq[0].cyc);
            void'(vq.pop_front());
          end
        end
      end
      begin
        logic [7:0] rd; int lo;
        while (!stop) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          cpu_xfer(1'($urandom_range(0, 1)), 11'($urandom_range(0, 1023)), 8'($urandom), 0, rd, lo);
        end
      end
    join
    n_tests += 2;
    if (starve_err !== 1'b0) begin n_fail++; $display("FAIL random_starve got %b want 0", starve_err); end
    bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) bad++;
    if (bad != 0) begin n_fail++; $display("FAIL ram_image got %0d differing bytes want 0", bad); end
  endtask

  task automatic test_starve();
    logic [7:0] rd; int lo;
    resetn = 1'b0;
    repeat (2) @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (z_starve !== 1'b0) begin n_fail++; $display("FAIL starve_pre got %b want 0", z_starve); end
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(posedge clk); #1;
          vid_req = 1'b1; vid_addr = 11'h400 + 11'($urandom_range(0, 1023));
          @(posedge clk); #1;
          vid_req = 1'b0;
        end
      end
      cpu_xfer(1'b0, 11'h040, 8'h00, 0, rd, lo);
    join
    n_tests += 2;
    if (z_starve !== 1'b1) begin n_fail++; $display("FAIL starve_set got %b want 1", z_starve); end
    if (starve_err !== 1'b0) begin n_fail++; $display("FAIL starve_default got %b want 0", starve_err); end
    repeat (20) @(negedge clk);
    n_tests++;
    if (z_starve !== 1'b1) begin n_fail++; $display("FAIL starve_sticky got %b want 1", z_starve); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[11'h010] = 8'h41;
    ref_mem[11'h010] = 8'h41;
    test_reset();
    test_reset_mid_write();
    test_read();
    test_vid_collision();
    test_cancel();
    test_scroll();
    test_back_to_back();
    test_random();
    test_starve();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
